// File: rtl/lap_stopwatch_if.sv
// Button inputs and display outputs of the lap stopwatch, grouped for the board/top level.
// master drives the raw buttons and observes the display; slave is the stopwatch itself.
interface lap_stopwatch_if #(
   parameter int DIGITS = 4,
   parameter int LAPS   = 8
);
   localparam int LW = $clog2(LAPS + 1);

   logic              btn_start;
   logic              btn_lap;
   logic              btn_recall;
   logic [4*DIGITS-1:0] cur_bcd;
   logic [4*DIGITS-1:0] show_bcd;
   logic [LW-1:0]     lap_count;
   logic [LW-1:0]     view_idx;
   logic              running;
   logic              lap_ovf;
   logic              wrap;
   logic [1:0]        view_state;

   modport master (
      output btn_start, btn_lap, btn_recall,
      input  cur_bcd, show_bcd, lap_count, view_idx, running, lap_ovf, wrap, view_state
   );

   modport slave (
      input  btn_start, btn_lap, btn_recall,
      output cur_bcd, show_bcd, lap_count, view_idx, running, lap_ovf, wrap, view_state
   );
endinterface

// File: rtl/lap_stopwatch.sv
// BCD stopwatch with lap memory: three synchronised buttons drive run/stop, lap capture/clear and recall.
// view_state exposes the LIVE/HOLD/RECALL display state for observation.
module lap_stopwatch #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 10,
   parameter int DIGITS  = 4,
   parameter int LAPS    = 8
) (
   input logic             clk,
   input logic             rst,
   lap_stopwatch_if.slave  bus
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam int LW  = $clog2(LAPS + 1);
   localparam int IW  = $clog2(LAPS);
   localparam int W   = 4 * DIGITS;

   typedef enum logic [1:0] {LIVE = 2'd0, HOLD = 2'd1, RECALL = 2'd2} view_t;

   view_t          state, state_n;
   logic [LW-1:0]  view_idx, view_n, ridx;
   logic [2:0]     sync_start, sync_lap, sync_recall;
   logic           start_p, lap_p, recall_p;
   logic           running, tick, wrap, lap_ovf, all9;
   logic [PW-1:0]  presc;
   logic [W-1:0]   cur_bcd, hold_bcd;
   logic [LW-1:0]  lap_count;
   logic [W-1:0]   mem [LAPS];

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      all9 = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (cur_bcd[4*i +: 4] != 4'd9) all9 = 1'b0;
   end

   // Bit 0 is the first synchroniser stage; bit 2 holds the previous synchronised level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_start  <= '0;
         sync_lap    <= '0;
         sync_recall <= '0;
      end else begin
         sync_start  <= {sync_start[1:0],  bus.btn_start};
         sync_lap    <= {sync_lap[1:0],    bus.btn_lap};
         sync_recall <= {sync_recall[1:0], bus.btn_recall};
      end
   end

   assign start_p  = sync_start[1]  & ~sync_start[2];
   assign lap_p    = sync_lap[1]    & ~sync_lap[2];
   assign recall_p = sync_recall[1] & ~sync_recall[2];
   assign tick     = running && (presc == PW'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= LIVE;
         view_idx <= '0;
      end else begin
         state    <= state_n;
         view_idx <= view_n;
      end
   end

   always_comb begin
      state_n = state;
      view_n  = view_idx;
      if (running) begin
         if (lap_p) begin
            view_n  = '0;
            state_n = (lap_count < LW'(LAPS)) ? HOLD : LIVE;
         end
      end else begin
         if (lap_p) begin
            view_n  = '0;
            state_n = LIVE;
         end else if (recall_p) begin
            view_n  = (view_idx < lap_count) ? view_idx + LW'(1) : '0;
            state_n = (view_n != '0) ? RECALL : LIVE;
         end
         if (start_p) begin
            view_n  = '0;
            state_n = LIVE;
         end
      end
   end

   // Captures use the pre-edge cur_bcd, so a lap coinciding with a tick stores the old time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         running   <= 1'b0;
         presc     <= '0;
         cur_bcd   <= '0;
         hold_bcd  <= '0;
         wrap      <= 1'b0;
         lap_count <= '0;
         lap_ovf   <= 1'b0;
         for (int i = 0; i < LAPS; i++) mem[i] <= '0;
      end else begin
         wrap <= 1'b0;
         if (running) begin
            if (tick) begin
               cur_bcd <= bcd_inc(cur_bcd);
               wrap    <= all9;
               presc   <= '0;
            end else begin
               presc <= presc + PW'(1);
            end
            if (lap_p) begin
               if (lap_count < LW'(LAPS)) begin
                  mem[lap_count[IW-1:0]] <= cur_bcd;
                  hold_bcd               <= cur_bcd;
                  lap_count              <= lap_count + LW'(1);
               end else begin
                  lap_ovf <= 1'b1;
               end
            end
            if (start_p) running <= 1'b0;
         end else begin
            if (lap_p) begin
               cur_bcd   <= '0;
               presc     <= '0;
               lap_count <= '0;
               lap_ovf   <= 1'b0;
            end
            if (start_p) running <= 1'b1;
         end
      end
   end

   assign ridx = view_idx - LW'(1);

   always_comb begin
      case (state)
         HOLD:    bus.show_bcd = hold_bcd;
         RECALL:  bus.show_bcd = mem[ridx[IW-1:0]];
         default: bus.show_bcd = cur_bcd;
      endcase
   end

   assign bus.cur_bcd    = cur_bcd;
   assign bus.lap_count  = lap_count;
   assign bus.view_idx   = view_idx;
   assign bus.running    = running;
   assign bus.lap_ovf    = lap_ovf;
   assign bus.wrap       = wrap;
   assign bus.view_state = state;
endmodule
